mac_xgmii_tx_serializer: RTL and testbench
==========================================

Name: mac_xgmii_tx_serializer

Overview:
- Downstream neighbour of the MAC frame generator.
- Accepts one fully assembled Ethernet frame as a wide flat register: preamble, SFD, header, payload and FCS.
- Streams the frame out as 64-bit XGMII-style beats with 8 per-lane control bits.
- Replaces preamble byte 0 with /S/, appends /T/, and enforces a minimum inter-packet gap of idles before the next frame can be accepted.

Parameters:
- PAYLOAD_MAX_SIZE, 1500: maximum payload bytes. Frame width is FRAME_W = PAYLOAD_MAX_SIZE*8 + 208 bits.
- IPG_BYTES, 12: minimum number of idle bytes after /T/ before the next /S/.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  frame available on i_frame/i_frame_len
- i_frame  in  FRAME_W  frame bytes; byte k = i_frame[8k+:8]; byte 0 is transmitted first
- i_frame_len  in  16  total frame bytes L, including preamble/SFD and FCS
- o_ready  out  1  block can accept a frame this cycle
- o_txd  out  64  lane n = o_txd[8n+:8]; lane 0 is first in time
- o_txc  out  8  per-lane control flag (1 = control character)
- o_busy  out  1  frame or IPG in progress
- o_frame_done  out  1  one-cycle pulse coincident with the /T/ beat
- o_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset i_rst_n.
- Reset values:
  - o_txd = 64'h0707070707070707, o_txc = 8'hFF (all idle)
  - o_busy = 0, o_frame_done = 0, o_err = 0
  - state = IDLE, so o_ready = 1
- All outputs are registered except o_ready, which is (state == IDLE).
- States:
  - IDLE: emit idles.
  - DATA: emit frame beats.
  - IPG: emit idle beats.
- Handshake:
  - A frame is accepted on a rising edge where i_valid && o_ready.
  - i_frame and i_frame_len are captured into internal registers; upstream may change its inputs afterwards.
- Length check:
  - Legal L is 26..FRAME_W/8.
  - An illegal L at acceptance pulses o_err for 1 cycle; state stays IDLE, no beats are emitted, o_ready stays 1.
- Latency: the first beat appears on o_txd in the cycle after acceptance.
- Beat count:
  - Frame occupies byte positions 0..L-1; /T/ sits at position L.
  - Beats B = floor(L/8) + 1. Beat b carries positions 8b..8b+7.
- Lane contents:
  - Position 0: 0xFB, txc = 1.
  - Positions 1..L-1: frame bytes, txc = 0.
  - Position L: 0xFD, txc = 1.
  - Positions > L in the last beat: 0x07, txc = 1.
- Terminate beat: o_frame_done = 1 and o_busy = 1 on beat B-1.
- IPG:
  - trailing = 7 - (L mod 8).
  - Extra idle beats N = ceil(max(0, IPG_BYTES - trailing) / 8).
  - If N = 0, go from DATA directly to IDLE; otherwise go to IPG for N cycles (o_busy = 1), then IDLE.
- Back-to-back:
  - o_ready rises in the first IDLE cycle; acceptance then puts /S/ on the next cycle.
  - With i_valid held high, the gap between frames is therefore N + 1 idle beats after the /T/ beat.
- i_valid while not IDLE is ignored; no error is raised.
- Reset mid-frame: outputs return to idle immediately (asynchronously). No /T/ is emitted, the captured frame is discarded, and the block restarts in IDLE.
- Beat counter width: clog2(FRAME_W/64 + 2). No wrap-around within a legal frame.

Test Plan:
- Minimum padded frame, L=72 (bytes 0..6 = 0x55, byte 7 = 0xD5):
  - Accept at cycle 0.
  - Cycle 1: o_txd = 64'hD5555555555555FB, o_txc = 8'h01.
  - Cycles 2..9: frame bytes, txc = 0.
  - Cycle 10: o_txd = 64'h07070707070707FD, o_txc = 8'hFF, o_frame_done = 1.
  - Cycle 11: one IPG beat (N = 1), all idle.
  - Cycle 12: o_ready = 1.
- L=27 (1-byte payload, no padding):
  - B = 4. Beat 3: lanes 0..2 = frame bytes 24..26 with txc = 0; lane 3 = 0xFD; lanes 4..7 = 0x07; o_txc = 8'hF8.
  - Then 1 IPG beat.
- L=25 and L=FRAME_W/8 + 1: o_err pulses 1 cycle, o_txd stays all-idle, o_ready stays 1, o_busy stays 0.
- L=1526 (max frame, 1500-byte payload):
  - B = 191; /T/ in lane 6 of beat 190, trailing = 1.
  - N = 2 IPG beats.
  - Frame bytes match the captured i_frame even if i_frame changes after acceptance.
- Back-to-back, i_valid held high, L=72 twice:
  - Second /S/ at cycle 13.
  - Exactly 2 all-idle beats (cycles 11 and 12) between the /T/ beat and /S/.
- Reset asserted during beat 4 of an L=72 frame:
  - Same cycle: o_txd = 64'h0707070707070707, o_txc = 8'hFF, o_busy = 0.
  - After release: o_ready = 1, no /T/ is ever emitted, a new frame transmits correctly.

Source files
------------

// File: rtl/mac_xgmii_tx_serializer.sv
// XGMII transmit serializer: takes one assembled Ethernet frame as a flat
// register and streams it as 64-bit beats with /S/, /T/ and an idle gap.
//
// Ports:
//   clk          - clock
//   i_rst_n      - asynchronous active-low reset
//   i_valid      - frame present on i_frame / i_frame_len
//   i_frame      - frame bytes, byte k = i_frame[8k+:8], byte 0 sent first
//   i_frame_len  - total frame bytes L (preamble/SFD through FCS)
//   o_ready      - block is idle and can accept a frame this cycle
//   o_txd        - 8 lanes of data, lane 0 first in time
//   o_txc        - per-lane control flag
//   o_busy       - frame or inter-packet gap in progress
//   o_frame_done - pulse on the beat carrying /T/
//   o_err        - pulse when a frame with an illegal length is rejected
module mac_xgmii_tx_serializer #(
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int IPG_BYTES        = 12,
    localparam int FRAME_W         = PAYLOAD_MAX_SIZE*8 + 208
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic [15:0]        i_frame_len,
    output logic               o_ready,
    output logic [63:0]        o_txd,
    output logic [7:0]         o_txc,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_err
);

    localparam int          CW      = $clog2(FRAME_W/64 + 2);
    localparam int          IW      = $clog2(IPG_BYTES/8 + 2);
    localparam logic [15:0] MIN_LEN = 16'd26;
    localparam logic [15:0] MAX_LEN = 16'(FRAME_W/8);
    localparam logic [63:0] IDLE_D  = {8{8'h07}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_IPG
    } state_t;

    state_t          r_state;
    logic [63:0]     r_txd;
    logic [7:0]      r_txc;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [CW-1:0]   r_beat;
    logic [CW-1:0]   r_last;
    logic [2:0]      r_lenlo;
    logic [IW-1:0]   r_ipgn;
    logic [IW-1:0]   r_ipgc;
    logic [FRAME_W-1:0] r_frame;

    state_t          w_state_nx;
    logic [63:0]     w_txd_nx;
    logic [7:0]      w_txc_nx;
    logic            w_busy_nx;
    logic            w_done_nx;
    logic            w_err_nx;
    logic [CW-1:0]   w_beat_nx;
    logic [CW-1:0]   w_last_nx;
    logic [2:0]      w_lenlo_nx;
    logic [IW-1:0]   w_ipgn_nx;
    logic [IW-1:0]   w_ipgc_nx;
    logic            w_load;
    logic            w_shift;
    logic            w_legal;
    logic [IW-1:0]   w_ipg_n;
    logic [CW-1:0]   w_beat_inc;
    logic            w_is_last;
    int              v_trail;
    int              v_def;

    assign o_ready      = (r_state == ST_IDLE);
    assign o_txd        = r_txd;
    assign o_txc        = r_txc;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_err        = r_err;

    assign w_legal    = (i_frame_len >= MIN_LEN) && (i_frame_len <= MAX_LEN);
    assign w_beat_inc = r_beat + 1'b1;
    assign w_is_last  = (w_beat_inc == r_last);

    // Idle beats needed after the /T/ beat: the lanes past /T/ already
    // count toward the gap, the remainder is rounded up to whole beats.
    always_comb begin
        v_trail = 7 - int'(i_frame_len[2:0]);
        v_def   = IPG_BYTES - v_trail;
        if (v_def < 0) begin
            v_def = 0;
        end
        w_ipg_n = IW'((v_def + 7) / 8);
    end

    // Builds {txc, txd} for one beat. On the last beat the lane holding
    // position L gets /T/, later lanes get idles.
    function automatic logic [71:0] f_beat(
        input logic [63:0] d,
        input logic        first,
        input logic        last,
        input logic [2:0]  lo
    );
        logic [63:0] t;
        logic [7:0]  c;
        t = d;
        c = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (last && (3'(n) == lo)) begin
                t[8*n +: 8] = 8'hFD;
                c[n]        = 1'b1;
            end else if (last && (3'(n) > lo)) begin
                t[8*n +: 8] = 8'h07;
                c[n]        = 1'b1;
            end
        end
        if (first) begin
            t[7:0] = 8'hFB;
            c[0]   = 1'b1;
        end
        return {c, t};
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_txd_nx   = IDLE_D;
        w_txc_nx   = 8'hFF;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_beat_nx  = r_beat;
        w_last_nx  = r_last;
        w_lenlo_nx = r_lenlo;
        w_ipgn_nx  = r_ipgn;
        w_ipgc_nx  = r_ipgc;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_valid && w_legal) begin
                    // Legal L >= 26 means beat 0 is never the /T/ beat.
                    w_state_nx           = ST_DATA;
                    {w_txc_nx, w_txd_nx} = f_beat(i_frame[63:0], 1'b1,
                                                  1'b0, 3'd0);
                    w_busy_nx  = 1'b1;
                    w_beat_nx  = '0;
                    w_last_nx  = CW'(i_frame_len >> 3);
                    w_lenlo_nx = i_frame_len[2:0];
                    w_ipgn_nx  = w_ipg_n;
                    w_load     = 1'b1;
                end else if (i_valid) begin
                    w_err_nx = 1'b1;
                end
            end
            ST_DATA: begin
                if (r_beat == r_last) begin
                    if (r_ipgn == '0) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_IPG;
                        w_ipgc_nx  = r_ipgn;
                        w_busy_nx  = 1'b1;
                    end
                end else begin
                    {w_txc_nx, w_txd_nx} = f_beat(r_frame[63:0], 1'b0,
                                                  w_is_last, r_lenlo);
                    w_beat_nx = w_beat_inc;
                    w_busy_nx = 1'b1;
                    w_done_nx = w_is_last;
                    w_shift   = 1'b1;
                end
            end
            ST_IPG: begin
                if (r_ipgc > IW'(1)) begin
                    w_ipgc_nx = r_ipgc - 1'b1;
                    w_busy_nx = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_txd   <= IDLE_D;
            r_txc   <= 8'hFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_last  <= '0;
            r_lenlo <= '0;
            r_ipgn  <= '0;
            r_ipgc  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_txd   <= w_txd_nx;
            r_txc   <= w_txc_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_beat  <= w_beat_nx;
            r_last  <= w_last_nx;
            r_lenlo <= w_lenlo_nx;
            r_ipgn  <= w_ipgn_nx;
            r_ipgc  <= w_ipgc_nx;
        end
    end

    // Frame store: bytes for the next beat always sit in the low 64 bits.
    // Contents are don't-care outside DATA, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_frame <= i_frame >> 64;
        end else if (w_shift) begin
            r_frame <= r_frame >> 64;
        end
    end

endmodule

// File: tb/tb_mac_xgmii_tx_serializer.sv
// Randomized bench for mac_xgmii_tx_serializer with a byte-position
// reference model of the transmitted beat stream.
module tb_mac_xgmii_tx_serializer;

    localparam int PAYLOAD_MAX_SIZE = 1500;
    localparam int IPG_BYTES        = 12;
    localparam int FRAME_W          = PAYLOAD_MAX_SIZE*8 + 208;
    localparam int MAX_L            = FRAME_W/8;
    localparam logic [63:0] IDLE64  = 64'h0707070707070707;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid;
    logic [FRAME_W-1:0] frame;
    logic [15:0]        flen;
    logic               ready;
    logic [63:0]        txd;
    logic [7:0]         txc;
    logic               busy;
    logic               done;
    logic               err;

    int n_chk  = 0;
    int n_pass = 0;

    mac_xgmii_tx_serializer #(
        .PAYLOAD_MAX_SIZE(PAYLOAD_MAX_SIZE),
        .IPG_BYTES(IPG_BYTES)
    ) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .i_frame(frame),
        .i_frame_len(flen),
        .o_ready(ready),
        .o_txd(txd),
        .o_txc(txc),
        .o_busy(busy),
        .o_frame_done(done),
        .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < MAX_L; k++) begin
            f[8*k +: 8] = 8'($urandom);
        end
        return f;
    endfunction

    // Expected beat b: byte positions 8b..8b+7 per the /S/, data, /T/,
    // idle rules.
    function automatic logic [71:0] exp_beat(input logic [FRAME_W-1:0] f,
                                             input int len, input int b);
        logic [63:0] d;
        logic [7:0]  c;
        for (int n = 0; n < 8; n++) begin
            int p;
            p = 8*b + n;
            if (p == 0) begin
                d[8*n +: 8] = 8'hFB; c[n] = 1'b1;
            end else if (p < len) begin
                d[8*n +: 8] = f[8*p +: 8]; c[n] = 1'b0;
            end else if (p == len) begin
                d[8*n +: 8] = 8'hFD; c[n] = 1'b1;
            end else begin
                d[8*n +: 8] = 8'h07; c[n] = 1'b1;
            end
        end
        return {c, d};
    endfunction

    function automatic int exp_ipg(input int len);
        int trail;
        int def;
        trail = 7 - (len % 8);
        def   = IPG_BYTES - trail;
        if (def < 0) def = 0;
        return (def + 7) / 8;
    endfunction

    // Called in the cycle after acceptance; returns in the first IDLE cycle.
    task automatic expect_frame(input logic [FRAME_W-1:0] f, input int len);
        int nb;
        int ni;
        logic [71:0] e;
        nb = len/8 + 1;
        ni = exp_ipg(len);
        for (int b = 0; b < nb; b++) begin
            e = exp_beat(f, len, b);
            chk($sformatf("txd L%0d b%0d", len, b), txd, e[63:0]);
            chk($sformatf("txc L%0d b%0d", len, b), 64'(txc), 64'(e[71:64]));
            chk($sformatf("done L%0d b%0d", len, b), 64'(done),
                64'(b == nb-1));
            chk($sformatf("busy L%0d b%0d", len, b), 64'(busy), 64'd1);
            chk($sformatf("err L%0d b%0d", len, b), 64'(err), 64'd0);
            step();
        end
        for (int k = 0; k < ni; k++) begin
            chk($sformatf("ipg txd L%0d", len), txd, IDLE64);
            chk($sformatf("ipg txc L%0d", len), 64'(txc), 64'hFF);
            chk($sformatf("ipg busy L%0d", len), 64'(busy), 64'd1);
            chk($sformatf("ipg rdy L%0d", len), 64'(ready), 64'd0);
            chk($sformatf("ipg done L%0d", len), 64'(done), 64'd0);
            step();
        end
        chk($sformatf("end rdy L%0d", len), 64'(ready), 64'd1);
        chk($sformatf("end busy L%0d", len), 64'(busy), 64'd0);
        chk($sformatf("end txd L%0d", len), txd, IDLE64);
        chk($sformatf("end txc L%0d", len), 64'(txc), 64'hFF);
    endtask

    task automatic send(input logic [FRAME_W-1:0] f, input int len);
        frame = f;
        flen  = 16'(len);
        valid = 1'b1;
        chk("pre rdy", 64'(ready), 64'd1);
        step();
        valid = 1'b0;
        frame = rand_frame();
        flen  = 16'($urandom);
        expect_frame(f, len);
    endtask

    task automatic send_bad(input int len);
        frame = rand_frame();
        flen  = 16'(len);
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk($sformatf("bad err L%0d", len), 64'(err), 64'd1);
        chk($sformatf("bad txd L%0d", len), txd, IDLE64);
        chk($sformatf("bad txc L%0d", len), 64'(txc), 64'hFF);
        chk($sformatf("bad rdy L%0d", len), 64'(ready), 64'd1);
        chk($sformatf("bad busy L%0d", len), 64'(busy), 64'd0);
        step();
        chk($sformatf("bad err2 L%0d", len), 64'(err), 64'd0);
        chk($sformatf("bad txd2 L%0d", len), txd, IDLE64);
    endtask

    initial begin
        logic [FRAME_W-1:0] f1;
        logic [FRAME_W-1:0] f2;
        int len;

        rst_n = 1'b0;
        valid = 1'b0;
        frame = '0;
        flen  = '0;
        #12;
        chk("rst txd", txd, IDLE64);
        chk("rst txc", 64'(txc), 64'hFF);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst rdy", 64'(ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Minimum padded frame with a real preamble/SFD.
        f1 = rand_frame();
        for (int k = 0; k < 7; k++) f1[8*k +: 8] = 8'h55;
        f1[63:56] = 8'hD5;
        frame = f1;
        flen  = 16'd72;
        valid = 1'b1;
        step();
        valid = 1'b0;
        frame = rand_frame();
        chk("min S beat", txd, 64'hD5555555555555FB);
        chk("min S txc", 64'(txc), 64'h01);
        expect_frame(f1, 72);

        send(rand_frame(), 27);
        send(rand_frame(), 26);
        send(rand_frame(), MAX_L);

        send_bad(25);
        send_bad(MAX_L + 1);
        send_bad(0);

        // Back-to-back with i_valid held high.
        f1 = rand_frame();
        f2 = rand_frame();
        frame = f1;
        flen  = 16'd72;
        valid = 1'b1;
        step();
        frame = f2;
        expect_frame(f1, 72);
        step();
        valid = 1'b0;
        frame = rand_frame();
        expect_frame(f2, 72);

        // Reset during beat 4.
        f1 = rand_frame();
        frame = f1;
        flen  = 16'd72;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre-rst b4", txd, f1[319:256]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst txd", txd, IDLE64);
        chk("mid rst txc", 64'(txc), 64'hFF);
        chk("mid rst busy", 64'(busy), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("post rst done", 64'(done), 64'd0);
            chk("post rst txc", 64'(txc), 64'hFF);
            step();
        end
        chk("post rst rdy", 64'(ready), 64'd1);
        send(rand_frame(), 72);

        // Randomized traffic with occasional illegal lengths and gaps.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    len = $urandom_range(0, 25);
                else
                    len = $urandom_range(MAX_L + 1, 65535);
                send_bad(len);
            end else begin
                if ($urandom_range(0, 3) == 0)
                    len = $urandom_range(26, MAX_L);
                else
                    len = $urandom_range(26, 120);
                send(rand_frame(), len);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                chk("gap txd", txd, IDLE64);
                chk("gap busy", 64'(busy), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
